// File: rtl/timer.sv
`default_nettype none
// ============================================================================
//  Module   : timer
//  Purpose  : Memory-mapped 32-bit timer/counter for data-bus slot 0x6.
//             A prescaled up-counter with compare match (one-shot or
//             periodic), overflow detection and a level interrupt.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    PRE_W   : prescaler width in bits (1..23, PRE lives in CTRL[8+PRE_W-1:8])
//    CMP_RST : reset value of COMPARE
//  Ports
//    clk     : memory clock
//    rst     : synchronous active-high reset
//    dcs     : chip-select for this slot
//    drd     : read strobe
//    dwe     : write strobe
//    dwst    : byte-lane write enables, bit n gates din[8n+7:8n]
//    dadrs   : address, only dadrs[4:2] decoded
//    din     : write data
//    dout    : registered read data, holds until the next read
//    irq     : level interrupt = IE & (MATCH | OVF)
//    pwm     : registered PWM output (only when TIMER_PWM_EN is defined)
//  Register map (offset = dadrs[4:2]*4)
//    0x00 COUNT, 0x04 COMPARE, 0x08 CTRL {PRE, IE, PERIODIC, EN},
//    0x0C STATUS {OVF, MATCH} write-1-to-clear, 0x10 DUTY (PWM build only)
//  Build option
//    TIMER_PWM_EN : adds the DUTY register and the pwm output
// ============================================================================
module timer #(
    parameter int          PRE_W   = 8,
    parameter logic [31:0] CMP_RST = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dcs,
    input  logic        drd,
    input  logic        dwe,
    input  logic [3:0]  dwst,
    input  logic [31:0] dadrs,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
`ifdef TIMER_PWM_EN
    ,
    output logic        pwm
`endif
);

    localparam logic [2:0] c_ADR_COUNT   = 3'd0;
    localparam logic [2:0] c_ADR_COMPARE = 3'd1;
    localparam logic [2:0] c_ADR_CTRL    = 3'd2;
    localparam logic [2:0] c_ADR_STATUS  = 3'd3;
    localparam logic [2:0] c_ADR_DUTY    = 3'd4;

    // Byte-lane merge of write data into an existing register value.
    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
        logic [31:0] v;
        v = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) v[8*i +: 8] = new_v[8*i +: 8];
        end
        return v;
    endfunction

    logic [31:0]      r_count;
    logic [31:0]      r_compare;
    logic             r_en;
    logic             r_periodic;
    logic             r_ie;
    logic [PRE_W-1:0] r_pre;
    logic [PRE_W-1:0] r_pcnt;
    logic             r_match;
    logic             r_ovf;
    logic [31:0]      r_dout;
    logic [31:0]      r_duty;
    logic             r_pwm;

    logic [2:0]  w_sel;
    logic        w_wr;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_ctrl;
    logic        w_wr_status;
    logic        w_wr_duty;
    logic        w_tick;
    logic        w_hit;
    logic        w_tick_eval;
    logic        w_set_match;
    logic        w_set_ovf;
    logic        w_clr_match;
    logic        w_clr_ovf;
    logic [31:0] w_ctrl_rd;
    logic [31:0] w_ctrl_wr;
    logic [31:0] w_rdata;
    logic        w_unused_bits;

    assign w_sel        = dadrs[4:2];
    assign w_wr         = dcs & dwe;
    assign w_wr_count   = w_wr & (w_sel == c_ADR_COUNT);
    assign w_wr_compare = w_wr & (w_sel == c_ADR_COMPARE);
    assign w_wr_ctrl    = w_wr & (w_sel == c_ADR_CTRL);
    assign w_wr_status  = w_wr & (w_sel == c_ADR_STATUS);
`ifdef TIMER_PWM_EN
    assign w_wr_duty    = w_wr & (w_sel == c_ADR_DUTY);
`else
    assign w_wr_duty    = 1'b0;
`endif

    // A tick fires on the cycle the prescaler reaches PRE. If new PRE is
    // below the current pcnt, pcnt keeps counting and wraps through 2^PRE_W.
    assign w_tick      = r_en & (r_pcnt == r_pre);
    assign w_hit       = (r_count == r_compare);
    // A software COUNT write in the same cycle suppresses all tick effects.
    assign w_tick_eval = w_tick & ~w_wr_count;
    assign w_set_match = w_tick_eval & w_hit;
    assign w_set_ovf   = w_tick_eval & ~w_hit & (&r_count);
    assign w_clr_match = w_wr_status & dwst[0] & din[0];
    assign w_clr_ovf   = w_wr_status & dwst[0] & din[1];

    always_comb begin
        w_ctrl_rd               = '0;
        w_ctrl_rd[0]            = r_en;
        w_ctrl_rd[1]            = r_periodic;
        w_ctrl_rd[2]            = r_ie;
        w_ctrl_rd[8 +: PRE_W]   = r_pre;
    end

    assign w_ctrl_wr = f_merge(w_ctrl_rd, din, dwst);

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            c_ADR_COUNT:   w_rdata = r_count;
            c_ADR_COMPARE: w_rdata = r_compare;
            c_ADR_CTRL:    w_rdata = w_ctrl_rd;
            c_ADR_STATUS:  w_rdata = {30'd0, r_ovf, r_match};
`ifdef TIMER_PWM_EN
            c_ADR_DUTY:    w_rdata = r_duty;
`endif
            default:       w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_compare  <= CMP_RST;
            r_en       <= 1'b0;
            r_periodic <= 1'b0;
            r_ie       <= 1'b0;
            r_pre      <= '0;
            r_pcnt     <= '0;
            r_match    <= 1'b0;
            r_ovf      <= 1'b0;
            r_dout     <= '0;
            r_duty     <= '0;
            r_pwm      <= 1'b0;
        end else begin
            // Prescaler
            if (!r_en || w_tick) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + PRE_W'(1);
            end

            // Counter
            if (w_wr_count) begin
                r_count <= f_merge(r_count, din, dwst);
            end else if (w_tick) begin
                if (w_hit) begin
                    if (r_periodic) r_count <= '0;
                end else begin
                    r_count <= r_count + 32'd1;
                end
            end

            if (w_wr_compare) r_compare <= f_merge(r_compare, din, dwst);

            if (w_wr_ctrl) begin
                r_en       <= w_ctrl_wr[0];
                r_periodic <= w_ctrl_wr[1];
                r_ie       <= w_ctrl_wr[2];
                r_pre      <= w_ctrl_wr[8 +: PRE_W];
            end
            // One-shot completion stops the timer; overrides a same-cycle CTRL write.
            if (w_set_match && !r_periodic) r_en <= 1'b0;

            // Hardware set takes priority over a simultaneous write-1-to-clear.
            r_match <= w_set_match | (r_match & ~w_clr_match);
            r_ovf   <= w_set_ovf   | (r_ovf   & ~w_clr_ovf);

            if (dcs && drd) r_dout <= w_rdata;

            if (w_wr_duty) r_duty <= f_merge(r_duty, din, dwst);
            r_pwm <= r_en & (r_count < r_duty);
        end
    end

    assign dout = r_dout;
    assign irq  = r_ie & (r_match | r_ovf);
`ifdef TIMER_PWM_EN
    assign pwm  = r_pwm;
    assign w_unused_bits = ^{dadrs[31:5], dadrs[1:0], w_ctrl_wr[7:3],
                             w_ctrl_wr[31:8+PRE_W]};
`else
    assign w_unused_bits = ^{dadrs[31:5], dadrs[1:0], w_ctrl_wr[7:3],
                             w_ctrl_wr[31:8+PRE_W], r_duty, r_pwm, c_ADR_DUTY};
`endif

endmodule
`default_nettype wire

// File: tb/tb_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timer
//  Purpose  : Self-checking bench for timer. Reads push expected data into a
//             scoreboard queue; a monitor pops and compares when read data
//             appears. Expected values come from a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_timer;

    localparam int PRE_W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dcs = 1'b0;
    logic        drd = 1'b0;
    logic        dwe = 1'b0;
    logic [3:0]  dwst = 4'h0;
    logic [31:0] dadrs = 32'h0;
    logic [31:0] din = 32'h0;
    logic [31:0] dout;
    logic        irq;
`ifdef TIMER_PWM_EN
    logic        pwm;
`endif

    always #5 clk = ~clk;

    timer #(.PRE_W(PRE_W), .CMP_RST(32'hFFFF_FFFF)) dut (
        .clk   (clk),
        .rst   (rst),
        .dcs   (dcs),
        .drd   (drd),
        .dwe   (dwe),
        .dwst  (dwst),
        .dadrs (dadrs),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
`ifdef TIMER_PWM_EN
        ,
        .pwm   (pwm)
`endif
    );

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        irqv;
    } exp_t;

    exp_t exp_q[$];
    logic pwm_q[$];
    int   checks = 0;
    int   errors = 0;

    // ---------------- behavioural model ----------------
    bit [31:0] m_count, m_cmp, m_duty;
    bit        m_en, m_per, m_ie, m_match, m_ovf;
    int        m_pre, m_pcnt;

    function automatic bit [31:0] merge(bit [31:0] o, bit [31:0] n, bit [3:0] be);
        bit [31:0] v;
        v = o;
        for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = n[8*i +: 8];
        return v;
    endfunction

    function automatic void m_reset();
        m_count = 0; m_cmp = 32'hFFFF_FFFF; m_duty = 0;
        m_en = 0; m_per = 0; m_ie = 0; m_match = 0; m_ovf = 0;
        m_pre = 0; m_pcnt = 0;
    endfunction

    function automatic bit [31:0] m_read(int ofs);
        case (ofs)
            0: return m_count;
            1: return m_cmp;
            2: return {16'd0, 8'(m_pre), 5'd0, m_ie, m_per, m_en};
            3: return {30'd0, m_ovf, m_match};
`ifdef TIMER_PWM_EN
            4: return m_duty;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one clock, optionally with a bus write.
    function automatic void m_step(bit wr, int ofs, bit [31:0] d, bit [3:0] be);
        bit        tick, cw, set_m, set_o, stop;
        bit [31:0] nc, ctl;
        int        np;
        tick = m_en && (m_pcnt == m_pre);
        np   = !m_en ? 0 : (tick ? 0 : (m_pcnt + 1) % (1 << PRE_W));
        cw   = wr && ofs == 0;
        set_m = 0; set_o = 0; stop = 0; nc = m_count;
        if (tick && !cw) begin
            if (m_count == m_cmp) begin
                set_m = 1;
                if (m_per) nc = 0; else stop = 1;
            end else begin
                if (m_count == 32'hFFFF_FFFF) set_o = 1;
                nc = m_count + 1;
            end
        end
`ifdef TIMER_PWM_EN
        pwm_q.push_back(m_en && (m_count < m_duty));
`endif
        if (wr) begin
            case (ofs)
                0: nc = merge(m_count, d, be);
                1: m_cmp = merge(m_cmp, d, be);
                2: begin
                    ctl = merge(m_read(2), d, be);
                    m_en = ctl[0]; m_per = ctl[1]; m_ie = ctl[2];
                    m_pre = int'(ctl[15:8]);
                end
                3: begin
                    if (be[0] && d[0]) m_match = 0;
                    if (be[0] && d[1]) m_ovf = 0;
                end
`ifdef TIMER_PWM_EN
                4: m_duty = merge(m_duty, d, be);
`endif
                default: ;
            endcase
        end
        m_count = nc;
        m_pcnt  = np;
        if (set_m) m_match = 1;
        if (set_o) m_ovf = 1;
        if (stop) m_en = 0;
    endfunction

    function automatic bit m_irq();
        return m_ie && (m_match || m_ovf);
    endfunction

    // ---------------- driver ----------------
    // kind: 0 idle, 1 write, 2 read. use_k selects a hand-derived read value.
    task automatic bus(input int kind, input int ofs, input logic [31:0] d,
                       input logic [3:0] be, input string nm,
                       input bit use_k, input logic [31:0] k);
        logic [31:0] hi, rv;
        exp_t e;
        @(negedge clk);
        hi    = $urandom();
        rst   = 1'b0;
        dcs   = (kind != 0);
        dwe   = (kind == 1);
        drd   = (kind == 2);
        dadrs = {hi[31:5], 3'(ofs), hi[1:0]};
        din   = d;
        dwst  = be;
        rv    = use_k ? k : m_read(ofs);
        m_step(kind == 1, ofs, d, be);
        if (kind == 2) begin
            e.name = nm; e.data = rv; e.irqv = m_irq();
            exp_q.push_back(e);
        end
    endtask

    task automatic wr(input int ofs, input logic [31:0] d, input logic [3:0] be = 4'hF);
        bus(1, ofs, d, be, "", 0, 32'd0);
    endtask

    task automatic rd(input int ofs, input string nm);
        bus(2, ofs, 32'd0, 4'h0, nm, 0, 32'd0);
    endtask

    task automatic rd_k(input int ofs, input logic [31:0] k, input string nm);
        bus(2, ofs, 32'd0, 4'h0, nm, 1, k);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(0, 0, 32'd0, 4'h0, "", 0, 32'd0);
    endtask

    task automatic do_reset(input bit with_read);
        exp_t e;
        @(negedge clk);
        rst = 1'b1; dcs = with_read; drd = with_read; dwe = 1'b0;
        dadrs = 32'h6000_0000;
        m_reset();
`ifdef TIMER_PWM_EN
        pwm_q.push_back(1'b0);
`endif
        if (with_read) begin
            e.name = "rst_read"; e.data = 32'd0; e.irqv = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic rd_issued;
        exp_t e;
        rd_issued = dcs & drd;
        #1;
        if (rd_issued === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read dout=%h required=none", dout);
            end else begin
                e = exp_q.pop_front();
                if (dout !== e.data || irq !== e.irqv) begin
                    errors++;
                    $display("FAIL %s dout=%h irq=%b required dout=%h irq=%b",
                             e.name, dout, irq, e.data, e.irqv);
                end
            end
        end
`ifdef TIMER_PWM_EN
        if (pwm_q.size() != 0) begin
            logic ep;
            ep = pwm_q.pop_front();
            checks++;
            if (pwm !== ep) begin
                errors++;
                $display("FAIL pwm_cycle pwm=%b required=%b", pwm, ep);
            end
        end
`endif
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r, v;
        int          ofs, hi_cnt;
        m_reset();
        do_reset(0);
        do_reset(0);

        // Reset values
        rd_k(0, 32'h0000_0000, "rst_count");
        rd_k(1, 32'hFFFF_FFFF, "rst_compare");
        rd_k(2, 32'h0000_0000, "rst_ctrl");
        rd_k(3, 32'h0000_0000, "rst_status");
        rd_k(4, 32'h0000_0000, "rst_duty");
        rd_k(6, 32'h0000_0000, "rst_unmapped");

        // Periodic compare at 5, PRE=0, IE
        wr(1, 32'd5);
        wr(2, 32'h7);
        for (int i = 0; i < 14; i++) rd(0, "periodic_count");
        rd(3, "periodic_status");
        wr(3, 32'h1);
        rd(3, "status_after_w1c");
        wr(2, 32'h0);
        wr(3, 32'h3);

        // One-shot, PRE=3, compare 2
        wr(0, 32'd0);
        wr(1, 32'd2);
        wr(2, 32'h0000_0301);
        rd(0, "oneshot_running");
        idle(20);
        rd_k(0, 32'd2, "oneshot_count");
        rd_k(2, 32'h0000_0300, "oneshot_ctrl");
        rd_k(3, 32'h1, "oneshot_status");
        wr(3, 32'h3);

        // Overflow: FFFF_FFFE, compare 0, EN + IE
        wr(0, 32'hFFFF_FFFE);
        wr(1, 32'd0);
        wr(2, 32'h5);
        rd_k(0, 32'hFFFF_FFFE, "ovf_count0");
        rd_k(0, 32'hFFFF_FFFF, "ovf_count1");
        rd_k(3, 32'h2, "ovf_status");

        // Byte-lane write
        wr(1, 32'h1234_5678);
        wr(1, 32'h0000_AB00, 4'b0010);
        rd_k(1, 32'h1234_AB78, "byte_lane");

        // COUNT write colliding with a tick
        wr(3, 32'h3);
        wr(1, 32'd1000);
        wr(2, 32'h3);
        wr(0, 32'h55);
        rd_k(0, 32'h55, "count_write_wins");
        wr(2, 32'h0);

`ifdef TIMER_PWM_EN
        // PWM: compare 9 periodic, duty 3
        wr(0, 32'd0);
        wr(1, 32'd9);
        wr(4, 32'd3);
        wr(2, 32'h3);
        idle(20);
        hi_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            idle(1);
            if (pwm === 1'b1) hi_cnt++;
        end
        checks++;
        if (hi_cnt != 9) begin
            errors++;
            $display("FAIL pwm_duty3 highs=%0d required=9", hi_cnt);
        end
        wr(4, 32'd0);
        idle(3);
        hi_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (pwm === 1'b1) hi_cnt++;
        end
        checks++;
        if (hi_cnt != 0) begin
            errors++;
            $display("FAIL pwm_duty0 highs=%0d required=0", hi_cnt);
        end
        wr(2, 32'h0);
`endif

        // Reset mid-count with a read in flight
        wr(2, 32'h1);
        idle(5);
        do_reset(1);
        rd_k(0, 32'd0, "post_rst_count");
        rd_k(1, 32'hFFFF_FFFF, "post_rst_compare");

        // Randomised traffic
        for (int n = 0; n < 500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 25) begin
                idle($urandom_range(1, 8));
            end else if (r < 55) begin
                rd($urandom_range(0, 7), "rand_read");
            end else begin
                ofs = $urandom_range(0, 5);
                v   = $urandom();
                case (ofs)
                    0: v = (v[0]) ? 32'($urandom_range(0, 15))
                                  : 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                    1: v = (v[0]) ? 32'($urandom_range(0, 15)) : v;
                    2: v = {16'd0, 8'($urandom_range(0, 3)), 5'd0, v[2:0]};
                    4: v = 32'($urandom_range(0, 16));
                    default: ;
                endcase
                r = $urandom();
                wr(ofs, v, r[0] ? 4'hF : r[4:1]);
            end
        end

        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_reads left=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
